// File: rtl/mips8_pkg.sv
// mips8_pkg: shared fetch states, opcode encodings and default fetch timeout.
package mips8_pkg;
  localparam int TIMEOUT_DEF = 16;
  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} fetch_state_t;
  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_LB    = 6'h20,
    OP_SB    = 6'h28
  } opcode_t;
endpackage

// File: rtl/instr_fetch_timeout_cnt.sv
// timeout_cnt: counts enabled cycles; expired flags the last allowed wait cycle.
module timeout_cnt
  import mips8_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_cnt <= '0;
    else if (clear) r_cnt <= '0;
    else if (enable) r_cnt <= r_cnt + W'(1);
  assign expired = r_cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: assembles a 32-bit little-endian instruction from four byte reads
// with per-byte ack timeout, flush and asynchronous reset.
module instr_fetch
  import mips8_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic [7:0]  pc,
  input  logic        flush,
  output logic        mem_req,
  output logic [7:0]  mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] instr,
  output logic [5:0]  op_code,
  output logic        instr_valid,
  output logic        busy,
  output logic        fetch_err
);
  fetch_state_t r_state, w_next;
  logic [7:0]  r_base;
  logic [1:0]  r_cnt;
  logic [31:0] r_instr;
  logic        r_valid, r_err;
  logic        w_start, w_ack, w_expired;
  assign w_start = fetch_start && r_state != REQ && !flush;
  assign w_ack   = r_state == REQ && mem_ack && !flush;
  always_comb begin
    w_next = r_state;
    if (flush) w_next = IDLE;
    else if (w_start) w_next = REQ;
    else if (w_ack && r_cnt == 2'd3) w_next = DONE;
    else if (r_state == REQ && !mem_ack && w_expired) w_next = ERR;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_base  <= '0;
      r_cnt   <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (flush) begin
      r_instr <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_start) begin
      r_base  <= pc;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_ack) begin
      r_instr[{r_cnt, 3'b000} +: 8] <= mem_rdata;
      if (r_cnt == 2'd3) r_valid <= 1'b1;
      else r_cnt <= r_cnt + 2'd1;
    end else if (r_state == REQ && w_expired) begin
      r_err <= 1'b1;
    end
  timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (flush || w_start || w_ack),
    .enable (r_state == REQ && !mem_ack),
    .expired(w_expired)
  );
  assign mem_req     = r_state == REQ;
  assign busy        = r_state == REQ;
  assign mem_addr    = r_base + {6'b0, r_cnt};
  assign instr       = r_instr;
  assign op_code     = r_instr[31:26];
  assign instr_valid = r_valid;
  assign fetch_err   = r_err;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed fetch scenarios with address/result scoreboard and monitor.
module tb_instr_fetch;
  logic        clk = 1'b0, reset = 1'b1, fetch_start = 1'b0, flush = 1'b0, mem_ack = 1'b0;
  logic [7:0]  pc = 8'h00;
  logic        mem_req, busy, instr_valid, fetch_err;
  logic [7:0]  mem_addr, mem_rdata;
  logic [31:0] instr;
  logic [5:0]  op_code;
  logic [7:0]  mem [256];
  int          n_cmp = 0, n_bad = 0;
  int          ack_wait = 0, wcnt = 0, c;
  bit          ack_never = 1'b0;
  typedef struct {bit err; logic [31:0] word;} res_t;
  logic [7:0]  exp_addr [$];
  res_t        exp_res [$];
  res_t        r;
  logic [7:0]  held;
  bit          waiting = 1'b0, pv = 1'b0, pe = 1'b0;

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];

  instr_fetch #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc(pc), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .instr(instr), .op_code(op_code), .instr_valid(instr_valid), .busy(busy),
    .fetch_err(fetch_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory responder: ack_wait idle cycles before each ack
  always @(negedge clk) begin
    if (!mem_req || ack_never) begin mem_ack = 1'b0; wcnt = 0; end
    else if (wcnt >= ack_wait) begin mem_ack = 1'b1; wcnt = 0; end
    else begin mem_ack = 1'b0; wcnt++; end
  end

  always @(negedge clk) begin
    #1;
    if (mem_req && waiting) chk("addr_hold", {24'b0, mem_addr}, {24'b0, held});
    waiting = mem_req && !mem_ack;
    held = mem_addr;
    if (mem_req && mem_ack) begin
      if (exp_addr.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL mem_addr: unexpected ack at %h", mem_addr);
      end else chk("mem_addr", {24'b0, mem_addr}, {24'b0, exp_addr.pop_front()});
    end
    if ((instr_valid && !pv) || (fetch_err && !pe)) begin
      if (exp_res.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL result: unexpected completion instr=%h err=%b", instr, fetch_err);
      end else begin
        r = exp_res.pop_front();
        chk("fetch_err", {31'b0, fetch_err}, {31'b0, r.err});
        if (!r.err) begin
          chk("instr", instr, r.word);
          chk("op_code", {26'b0, op_code}, {26'b0, r.word[31:26]});
        end
      end
    end
    pv = instr_valid;
    pe = fetch_err;
  end

  task automatic start(input logic [7:0] a);
    @(negedge clk); pc = a; fetch_start = 1'b1;
    @(negedge clk); fetch_start = 1'b0;
  endtask

  task automatic expect_fetch(input logic [7:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) exp_addr.push_back(a + 8'(k));
    exp_res.push_back('{1'b0, w});
  endtask

  task automatic wait_end(input int budget, output int bc);
    bc = 0;
    repeat (budget) begin
      #1;
      if (instr_valid || fetch_err) return;
      bc += int'(busy);
      @(negedge clk);
    end
    n_cmp++; n_bad++;
    $display("FAIL wait_end: no completion within %0d cycles", budget);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7);
    {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]} = {8'h20, 8'h00, 8'h01, 8'h80};
    {mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]} = {8'h11, 8'h22, 8'h33, 8'h44};
    {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]} = {8'h78, 8'h56, 8'h34, 8'h12};
    {mem[8'h70], mem[8'h71], mem[8'h72], mem[8'h73]} = {8'h01, 8'h02, 8'h03, 8'hFC};
    #12;
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_mem_addr", {24'b0, mem_addr}, 0);
    chk("rst_instr", instr, 0);
    chk("rst_valid", {31'b0, instr_valid}, 0);
    chk("rst_err", {31'b0, fetch_err}, 0);
    @(negedge clk); reset = 1'b0;

    expect_fetch(8'h10, 32'h80010020);
    start(8'h10);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("lat_req", {31'b0, mem_req}, 1);
      chk("lat_valid_early", {31'b0, instr_valid}, 0);
      @(negedge clk);
    end
    #1;
    chk("lat_valid_c5", {31'b0, instr_valid}, 1);
    chk("lat_req_c5", {31'b0, mem_req}, 0);
    chk("op_code_t1", {26'b0, op_code}, 32'h20);
    repeat (3) @(negedge clk);
    #1;
    chk("done_hold_valid", {31'b0, instr_valid}, 1);
    chk("done_hold_instr", instr, 32'h80010020);

    ack_wait = 2;
    expect_fetch(8'hFE, 32'h44332211);
    start(8'hFE);
    wait_end(40, c);
    chk("wrap_busy_cycles", c, 12);
    chk("wrap_err", {31'b0, fetch_err}, 0);

    ack_never = 1'b1;
    exp_res.push_back('{1'b1, 32'h0});
    start(8'h50);
    wait_end(40, c);
    chk("timeout_cycles", c, 16);
    chk("timeout_err", {31'b0, fetch_err}, 1);
    chk("timeout_req", {31'b0, mem_req}, 0);
    chk("timeout_valid", {31'b0, instr_valid}, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("err_hold", {31'b0, fetch_err}, 1);
    ack_never = 1'b0;

    ack_wait = 0;
    for (int k = 0; k < 4; k++) exp_addr.push_back(8'h30 + 8'(k));
    start(8'h30);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    #1;
    chk("flush_instr", instr, 0);
    chk("flush_busy", {31'b0, busy}, 0);
    chk("flush_valid", {31'b0, instr_valid}, 0);
    chk("flush_err", {31'b0, fetch_err}, 0);
    expect_fetch(8'h40, 32'h12345678);
    start(8'h40);
    wait_end(20, c);
    chk("post_flush_cycles", c, 4);
    chk("post_flush_op", {26'b0, op_code}, 32'h04);

    @(negedge clk); flush = 1'b1; fetch_start = 1'b1; pc = 8'h99;
    @(negedge clk); flush = 1'b0; fetch_start = 1'b0;
    #1;
    chk("flush_start_busy", {31'b0, busy}, 0);
    chk("flush_start_instr", instr, 0);
    @(negedge clk);
    #1;
    chk("flush_start_idle", {31'b0, mem_req}, 0);

    ack_wait = 2;
    start(8'h60);
    #1;
    chk("pre_reset_req", {31'b0, mem_req}, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_req", {31'b0, mem_req}, 0);
    chk("async_rst_busy", {31'b0, busy}, 0);
    chk("async_rst_addr", {24'b0, mem_addr}, 0);
    #1 reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("post_rst_no_req", {31'b0, mem_req}, 0);
    end

    expect_fetch(8'h70, 32'hFC030201);
    start(8'h70);
    @(negedge clk); pc = 8'h00; fetch_start = 1'b1;
    @(negedge clk); fetch_start = 1'b0;
    wait_end(40, c);
    chk("ignored_start_cycles", c, 10);

    repeat (2) @(negedge clk);
    chk("addr_q_empty", exp_addr.size(), 0);
    chk("res_q_empty", exp_res.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
